order_dispatch_arbiter: RTL and testbench

Shares the single outbound order port between several strategy cores, each of which raises an order request carrying its price. Every strategy core is a copy of the spread/inference trading core. The block grants requests round-robin and caps the order rate with a token bucket. It forces silence while the risk kill switch is high, and presents the granted order on a valid/ready handshake to the downstream order encoder.

---
 rtl/order_dispatch_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_order_dispatch_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/order_dispatch_arbiter.sv
// Round-robin dispatch of strategy-core orders onto one outbound port, rate-capped by a token
// bucket and silenced by the risk kill switch. Define THROTTLE_STATS_EN to build the throttle counter.
module order_dispatch_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int PRICE_W       = 32,
  parameter int MAX_TOKENS    = 8,
  parameter int REFILL_CYCLES = 1000
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*PRICE_W-1:0]       req_price,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic                             kill_switch,
  output logic                             ord_valid,
  output logic [PRICE_W-1:0]               ord_price,
  output logic [$clog2(NUM_REQ)-1:0]       ord_src,
  input  logic                             ord_ready,
  output logic [$clog2(MAX_TOKENS+1)-1:0]  tokens_avail,
  output logic                             throttled,
  output logic [15:0]                      throttle_count
);

  localparam int SRC_W = $clog2(NUM_REQ);
  localparam int TOK_W = $clog2(MAX_TOKENS + 1);
  localparam int CNT_W = $clog2(REFILL_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEND   = 2'd1,
    ST_KILLED = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [SRC_W-1:0]     rr_q, rr_d;
  logic [TOK_W-1:0]     bucket_q, bucket_d;
  logic [CNT_W-1:0]     refill_q, refill_d;
  logic                 ord_valid_q, ord_valid_d;
  logic [PRICE_W-1:0]   ord_price_q, ord_price_d;
  logic [SRC_W-1:0]     ord_src_q, ord_src_d;
  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
  logic                 throttled_q, throttled_d;

  logic                 win_found_s;
  logic [SRC_W-1:0]     win_idx_s;
  logic [SRC_W:0]       cand_sum_s;
  logic [SRC_W-1:0]     cand_idx_s;
  logic                 cand_hit_s;
  logic [PRICE_W-1:0]   win_price_s;
  logic                 accept_s;
  logic                 wrap_s;

  // Round-robin search: first pending requester at or above rr_q, wrapping modulo NUM_REQ.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_sum_s  = '0;
    cand_idx_s  = '0;
    cand_hit_s  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum_s  = {1'b0, rr_q} + (SRC_W+1)'(k);
      cand_idx_s  = (cand_sum_s >= (SRC_W+1)'(NUM_REQ)) ?
                    SRC_W'(cand_sum_s - (SRC_W+1)'(NUM_REQ)) : SRC_W'(cand_sum_s);
      cand_hit_s  = !win_found_s && req_valid[cand_idx_s];
      win_idx_s   = cand_hit_s ? cand_idx_s : win_idx_s;
      win_found_s = win_found_s | cand_hit_s;
    end
  end

  assign win_price_s = req_price[win_idx_s*PRICE_W +: PRICE_W];
  assign accept_s    = (state_q == ST_SEND) && ord_valid_q && ord_ready;
  assign wrap_s      = (refill_q == CNT_W'(REFILL_CYCLES - 1));

  // Dispatch FSM next-state and order capture.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    ord_valid_d = ord_valid_q;
    ord_price_d = ord_price_q;
    ord_src_d   = ord_src_q;
    req_ready_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (kill_switch) begin
          state_d = ST_KILLED;
        end else if (win_found_s && (bucket_q != '0)) begin
          state_d     = ST_SEND;
          ord_valid_d = 1'b1;
          ord_price_d = win_price_s;
          ord_src_d   = win_idx_s;
          req_ready_d = NUM_REQ'(1) << win_idx_s;
          rr_d        = (win_idx_s == SRC_W'(NUM_REQ - 1)) ? '0 : win_idx_s + SRC_W'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        // A completed handshake has already been taken downstream, so it wins over a kill.
        if (accept_s) begin
          ord_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else if (kill_switch) begin
          ord_valid_d = 1'b0;
          state_d     = ST_KILLED;
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_KILLED: begin
        ord_valid_d = 1'b0;
        if (kill_switch) begin
          state_d = ST_KILLED;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        ord_valid_d = 1'b0;
      end
    endcase
  end

  // Token bucket level and free-running refill counter.
  always_comb begin
    refill_d = wrap_s ? '0 : refill_q + CNT_W'(1);
    if (accept_s && !wrap_s) begin
      bucket_d = bucket_q - TOK_W'(1);
    end else if (wrap_s && !accept_s && (bucket_q != TOK_W'(MAX_TOKENS))) begin
      bucket_d = bucket_q + TOK_W'(1);
    end else begin
      bucket_d = bucket_q;
    end
    throttled_d = (|req_valid) && (state_q == ST_IDLE) && (bucket_q == '0);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_q        <= '0;
      bucket_q    <= TOK_W'(MAX_TOKENS);
      refill_q    <= '0;
      ord_valid_q <= 1'b0;
      ord_price_q <= '0;
      ord_src_q   <= '0;
      req_ready_q <= '0;
      throttled_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      bucket_q    <= bucket_d;
      refill_q    <= refill_d;
      ord_valid_q <= ord_valid_d;
      ord_price_q <= ord_price_d;
      ord_src_q   <= ord_src_d;
      req_ready_q <= req_ready_d;
      throttled_q <= throttled_d;
    end
  end

`ifdef THROTTLE_STATS_EN
  logic [15:0] tcount_q, tcount_d;

  // Saturating count of edges that load throttled high.
  always_comb begin
    if (throttled_d && (tcount_q != 16'hFFFF)) begin
      tcount_d = tcount_q + 16'd1;
    end else begin
      tcount_d = tcount_q;
    end
  end

  // Throttle statistic register; cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcount_q <= 16'h0000;
    end else begin
      tcount_q <= tcount_d;
    end
  end

  assign throttle_count = tcount_q;
`else
  assign throttle_count = 16'h0000;
`endif

  assign req_ready    = req_ready_q;
  assign ord_valid    = ord_valid_q;
  assign ord_price    = ord_price_q;
  assign ord_src      = ord_src_q;
  assign tokens_avail = bucket_q;
  assign throttled    = throttled_q;

endmodule

// File: tb/tb_order_dispatch_arbiter.sv
// Self-checking bench for order_dispatch_arbiter: directed scenarios plus a randomized run
// against an order-level reference model.
module tb_order_dispatch_arbiter;
  localparam int NREQ = 4;
  localparam int PW   = 32;
  localparam int MAXT = 8;
  localparam int RC   = 100;
`ifdef THROTTLE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NREQ-1:0]  req_valid = '0;
  logic [NREQ*PW-1:0] req_price = '0;
  logic [NREQ-1:0]  req_ready;
  logic             kill_switch = 1'b0;
  logic             ord_valid;
  logic [PW-1:0]    ord_price;
  logic [1:0]       ord_src;
  logic             ord_ready = 1'b0;
  logic [3:0]       tokens_avail;
  logic             throttled;
  logic [15:0]      throttle_count;

  int total = 0;
  int bad   = 0;

  order_dispatch_arbiter #(.NUM_REQ(NREQ), .PRICE_W(PW), .MAX_TOKENS(MAXT), .REFILL_CYCLES(RC)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_price(req_price), .req_ready(req_ready),
    .kill_switch(kill_switch), .ord_valid(ord_valid), .ord_price(ord_price), .ord_src(ord_src),
    .ord_ready(ord_ready), .tokens_avail(tokens_avail), .throttled(throttled),
    .throttle_count(throttle_count)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 = waiting for work, 1 = order outstanding, 2 = silenced.
  int          m_mode, m_rr, m_tok, m_edges, m_src, m_tcnt, m_pick;
  logic        m_valid, m_throt;
  logic [PW-1:0] m_price;
  logic [NREQ-1:0] m_ready;
  logic        m_wrap, m_acc, m_starve;

  function automatic int rr_pick(input logic [NREQ-1:0] mask, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  always_comb m_pick = rr_pick(req_valid, m_rr);
  assign m_wrap   = ((m_edges % RC) == RC - 1);
  assign m_acc    = (m_mode == 1) && ord_ready;
  assign m_starve = (req_valid != '0) && (m_mode == 0) && (m_tok == 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0; m_rr <= 0; m_tok <= MAXT; m_edges <= 0; m_src <= 0; m_tcnt <= 0;
      m_valid <= 1'b0; m_throt <= 1'b0; m_price <= '0; m_ready <= '0;
    end else begin
      m_edges <= m_edges + 1;
      m_ready <= '0;
      m_throt <= m_starve;
      if (STATS && m_starve && m_tcnt < 65535) m_tcnt <= m_tcnt + 1;
      if (m_acc && !m_wrap) m_tok <= m_tok - 1;
      else if (m_wrap && !m_acc && m_tok < MAXT) m_tok <= m_tok + 1;
      case (m_mode)
        0: if (kill_switch) m_mode <= 2;
           else if (m_pick >= 0 && m_tok > 0) begin
             m_mode  <= 1;
             m_valid <= 1'b1;
             m_price <= req_price[m_pick*PW +: PW];
             m_src   <= m_pick;
             m_ready <= NREQ'(1) << m_pick;
             m_rr    <= (m_pick + 1) % NREQ;
           end
        1: if (ord_ready) begin m_mode <= 0; m_valid <= 1'b0; end
           else if (kill_switch) begin m_mode <= 2; m_valid <= 1'b0; end
        default: if (!kill_switch) m_mode <= 0;
      endcase
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; kill_switch = 1'b0; ord_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) req_price[i*PW +: PW] = $urandom();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (ord_valid !== 1'b0 || ord_price !== 32'd0 || ord_src !== 2'd0 || req_ready !== 4'd0 ||
        tokens_avail !== 4'd8 || throttled !== 1'b0 || throttle_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_values: got v=%0b p=%0d s=%0d rr=%b t=%0d th=%0b c=%0d want 0 0 0 0 8 0 0",
               ord_valid, ord_price, ord_src, req_ready, tokens_avail, throttled, throttle_count);
    end
    do_reset();
    req_valid = 4'b0001; ord_ready = 1'b0;
    @(negedge clk);
    total++;
    if (ord_valid !== 1'b1) begin bad++; $display("FAIL reset_pregrant: got %0b want 1", ord_valid); end
    rst_n = 1'b0;
    #1;
    total++;
    if (ord_valid !== 1'b0 || tokens_avail !== 4'd8) begin
      bad++; $display("FAIL reset_mid_send: got v=%0b t=%0d want v=0 t=8", ord_valid, tokens_avail);
    end
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0100; req_price[2*PW +: PW] = 32'd1000; ord_ready = 1'b1;
    @(negedge clk);
    total++;
    if (req_ready !== 4'b0100 || ord_valid !== 1'b1 || ord_price !== 32'd1000 || ord_src !== 2'd2 ||
        tokens_avail !== 4'd8) begin
      bad++;
      $display("FAIL single_grant: got rr=%b v=%0b p=%0d s=%0d t=%0d want 0100 1 1000 2 8",
               req_ready, ord_valid, ord_price, ord_src, tokens_avail);
    end
    req_valid = '0;
    @(negedge clk);
    total++;
    if (ord_valid !== 1'b0 || req_ready !== 4'd0 || tokens_avail !== 4'd7) begin
      bad++; $display("FAIL single_accept: got v=%0b rr=%b t=%0d want 0 0000 7", ord_valid, req_ready, tokens_avail);
    end
  endtask

  task automatic test_fairness();
    int ngr = 0;
    int prev = 0;
    do_reset();
    req_valid = 4'b1111; ord_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        total++;
        if (ngr >= 8 || req_ready !== (4'b0001 << (ngr % 4)) || ord_src !== 2'(ngr % 4) ||
            ord_price !== req_price[(ngr % 4)*PW +: PW] || (ngr > 0 && m_edges - prev != 2)) begin
          bad++;
          $display("FAIL fairness_order: grant %0d got rr=%b s=%0d gap=%0d want src %0d gap 2",
                   ngr, req_ready, ord_src, m_edges - prev, ngr % 4);
        end
        prev = m_edges;
        ngr++;
      end
    end
    total++;
    if (ngr != 8 || tokens_avail !== 4'd0 || throttled !== 1'b1) begin
      bad++; $display("FAIL fairness_drain: got n=%0d t=%0d th=%0b want 8 0 1", ngr, tokens_avail, throttled);
    end
  endtask

  task automatic test_backpressure();
    logic [PW-1:0] p0;
    do_reset();
    req_valid = 4'b0010; ord_ready = 1'b0;
    @(negedge clk);
    p0 = req_price[PW +: PW];
    req_valid = 4'b1101;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if (ord_valid !== 1'b1 || ord_price !== p0 || ord_src !== 2'd1 || req_ready !== 4'd0) begin
        bad++;
        $display("FAIL backpressure_hold: cycle %0d got v=%0b p=%0d s=%0d rr=%b want 1 %0d 1 0000",
                 c, ord_valid, ord_price, ord_src, req_ready, p0);
      end
    end
    ord_ready = 1'b1; req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (ord_valid !== 1'b0 || tokens_avail !== 4'd7) begin
        bad++; $display("FAIL backpressure_accept: cycle %0d got v=%0b t=%0d want 0 7", c, ord_valid, tokens_avail);
      end
    end
  endtask

  task automatic test_refill();
    int g[10];
    int ng = 0;
    for (int i = 0; i < 10; i++) g[i] = 0;
    do_reset();
    req_valid = 4'b0001; ord_ready = 1'b1;
    for (int c = 0; c < 3*RC && ng < 10; c++) begin
      @(negedge clk);
      if (req_ready[0]) begin g[ng] = m_edges; ng++; end
    end
    total++;
    if (ng != 10 || g[8] != RC + 1 || g[9] - g[8] != RC) begin
      bad++; $display("FAIL refill_timing: got n=%0d g8=%0d gap=%0d want 10 %0d %0d", ng, g[8], g[9]-g[8], RC+1, RC);
    end
    ord_ready = 1'b0;
    for (int c = 0; c < 3*RC && m_edges < 3*RC - 1; c++) @(negedge clk);
    ord_ready = 1'b1; req_valid = '0;
    total++;
    if (ord_valid !== 1'b1 || tokens_avail !== 4'd1) begin
      bad++; $display("FAIL refill_prewrap: got v=%0b t=%0d want 1 1", ord_valid, tokens_avail);
    end
    @(negedge clk);
    total++;
    if (ord_valid !== 1'b0 || tokens_avail !== 4'd1) begin
      bad++; $display("FAIL refill_wrap_accept: got v=%0b t=%0d want 0 1", ord_valid, tokens_avail);
    end
  endtask

  task automatic test_kill();
    bit found = 1'b0;
    do_reset();
    req_valid = 4'b0010; ord_ready = 1'b0;
    @(negedge clk);
    total++;
    if (req_ready !== 4'b0010 || ord_src !== 2'd1) begin
      bad++; $display("FAIL kill_pregrant: got rr=%b s=%0d want 0010 1", req_ready, ord_src);
    end
    req_valid = 4'b1101; kill_switch = 1'b1;
    @(negedge clk);
    total++;
    if (ord_valid !== 1'b0 || tokens_avail !== 4'd8) begin
      bad++; $display("FAIL kill_drop: got v=%0b t=%0d want 0 8", ord_valid, tokens_avail);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (ord_valid !== 1'b0 || req_ready !== 4'd0) begin
        bad++; $display("FAIL kill_silent: cycle %0d got v=%0b rr=%b want 0 0000", c, ord_valid, req_ready);
      end
    end
    kill_switch = 1'b0; ord_ready = 1'b1;
    for (int c = 0; c < 6 && !found; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        found = 1'b1;
        total++;
        if (req_ready !== 4'b0100 || ord_src !== 2'd2 || tokens_avail !== 4'd8) begin
          bad++; $display("FAIL kill_resume: got rr=%b s=%0d t=%0d want 0100 2 8", req_ready, ord_src, tokens_avail);
        end
      end
    end
    total++;
    if (!found) begin bad++; $display("FAIL kill_resume_timeout: got no grant want one within 6 cycles"); end
  endtask

  task automatic test_stats();
    bit seen = 1'b0;
    do_reset();
    req_valid = 4'b0001; ord_ready = 1'b1;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      seen = throttled;
    end
    total++;
    if (!seen || throttle_count !== (STATS ? 16'd1 : 16'd0)) begin
      bad++; $display("FAIL stats_first: got seen=%0b c=%0d want 1 %0d", seen, throttle_count, STATS ? 1 : 0);
    end
    repeat (49) @(negedge clk);
    total++;
    if (throttled !== 1'b1 || tokens_avail !== 4'd0 || throttle_count !== (STATS ? 16'd50 : 16'd0)) begin
      bad++;
      $display("FAIL stats_count: got th=%0b t=%0d c=%0d want 1 0 %0d", throttled, tokens_avail, throttle_count, STATS ? 50 : 0);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      total++;
      if (ord_valid !== m_valid || ord_price !== m_price || ord_src !== 2'(m_src) || req_ready !== m_ready ||
          tokens_avail !== 4'(m_tok) || throttled !== m_throt || throttle_count !== 16'(m_tcnt)) begin
        bad++;
        $display("FAIL random_cycle %0d: got v=%0b p=%0h s=%0d rr=%b t=%0d th=%0b c=%0d want %0b %0h %0d %b %0d %0b %0d",
                 c, ord_valid, ord_price, ord_src, req_ready, tokens_avail, throttled, throttle_count,
                 m_valid, m_price, m_src, m_ready, m_tok, m_throt, m_tcnt);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) begin
          if ($urandom_range(1, 0) == 0) req_valid[i] = 1'b0;
          else req_price[i*PW +: PW] = $urandom();
        end else if (!req_valid[i] && $urandom_range(3, 0) == 0) begin
          req_valid[i] = 1'b1;
          req_price[i*PW +: PW] = $urandom();
        end
      end
      if ($urandom_range(24, 0) == 0) kill_switch = ~kill_switch;
      ord_ready = ($urandom_range(2, 0) != 0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_refill();
    test_kill();
    test_stats();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
